// File: rtl/adc_capture_ctrl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctrl
//
// Capture sequencer for the DSO sample buffer. Decimates the two 8-bit ADC
// channels, writes {adc_b, adc_a} into a circular RAM, applies a level/edge
// (or forced) trigger, stops after a programmed number of post-trigger
// samples, then freezes the buffer and publishes the trigger address until
// the host re-arms or reconfigures.
//
// Ports
//   clk         system clock
//   rst_n       synchronous active-low reset
//   adc_a/adc_b channel samples, valid every clock
//   adc_cfg     [7:0] trig_level, [8] trig_ch, [9] trig_slope (1=falling),
//               [10] force, [11] run, [22:12] post_count, [31:24] clk_div
//   cfg_stb     pulse: adc_cfg updated, abort and restart (run) or stop
//   rearm       pulse: host finished reading, start a new capture from DONE
//   wr_en       RAM write strobe, one cycle per decimated sample
//   wr_addr     RAM write address (advances after each write cycle)
//   wr_data     {adc_b, adc_a}
//   trig_addr   RAM address holding the trigger sample
//   oldest_addr oldest valid sample once frozen
//   status      {done, triggered, armed, busy}
// ---------------------------------------------------------------------------
module adc_capture_ctrl #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    adc_a,
  input  logic [7:0]    adc_b,
  input  logic [31:0]   adc_cfg,
  input  logic          cfg_stb,
  input  logic          rearm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [15:0]   wr_data,
  output logic [AW-1:0] trig_addr,
  output logic [AW-1:0] oldest_addr,
  output logic [3:0]    status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic [11:0] DEPTH = 12'(1 << AW);

  // Configuration fields, read live from the SPI-written register.
  logic [7:0]  trig_level;
  logic        trig_ch;
  logic        trig_slope;
  logic        force_trig;
  logic        run;
  logic [10:0] post_count;
  logic [7:0]  clk_div;
  logic        cfg_unused;

  assign trig_level = adc_cfg[7:0];
  assign trig_ch    = adc_cfg[8];
  assign trig_slope = adc_cfg[9];
  assign force_trig = adc_cfg[10];
  assign run        = adc_cfg[11];
  assign post_count = adc_cfg[22:12];
  assign cfg_unused = adc_cfg[23];
  assign clk_div    = adc_cfg[31:24];

  state_t      state;
  logic [7:0]  div_cnt;
  logic [AW:0] pre_cnt;
  logic [10:0] post_cnt;
  logic [7:0]  prev_sample;

  // Number of pre-trigger writes before arming. It is one write when the
  // post-trigger window covers (nearly) the whole buffer, so the trigger
  // comparison always has a previous sample to look at.
  logic [AW:0] pre_target;

  always_comb begin
    // NOTE: every combinational output gets a value on every path (default
    // first), otherwise synthesis infers a latch to hold the old value.
    pre_target = '0;
    if ({1'b0, post_count} >= DEPTH - 12'd1) begin
      pre_target = (AW+1)'(1);
    end else begin
      pre_target = (AW+1)'(DEPTH - {1'b0, post_count});
    end
  end

  // Decisions are taken at the end of each write cycle on the sample that
  // is being written, so trig_addr is simply the current wr_addr.
  logic [7:0] sample;
  logic       level_hit;
  logic       trig_hit;
  logic       post_done;
  logic       capture_end;
  logic       busy_st;
  logic       tick;
  logic       issue;
  logic       pre_last;
  logic       post_last;

  assign sample    = trig_ch ? wr_data[15:8] : wr_data[7:0];
  assign level_hit = trig_slope ? (prev_sample > trig_level && sample <= trig_level)
                                : (prev_sample < trig_level && sample >= trig_level);
  assign pre_last  = (pre_cnt + (AW+1)'(1)) == pre_target;
  assign post_last = ({1'b0, post_cnt} + 12'd1) == {1'b0, post_count};
  assign trig_hit  = (state == S_ARMED) && wr_en && (force_trig || level_hit);
  assign post_done = (state == S_POST) && wr_en && post_last;

  // The capture ends on this edge: a tick landing here must not write,
  // so nothing is written once done is visible.
  assign capture_end = (trig_hit && (post_count == '0)) || post_done;
  assign busy_st     = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
  assign tick        = (div_cnt == clk_div);
  assign issue       = tick && busy_st && !capture_end;

  function automatic logic [3:0] status_of(input state_t s);
    logic [3:0] st;
    st = 4'b0000;
    case (s)
      S_PREFILL: st = 4'b0001;
      S_ARMED:   st = 4'b0011;
      S_POST:    st = 4'b0101;
      S_DONE:    st = 4'b1100;
      default:   st = 4'b0000;
    endcase
    return st;
  endfunction

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values; later assignments in the block
  // override the defaults given at its top.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      status      <= 4'b0000;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      trig_addr   <= '0;
      oldest_addr <= '0;
      div_cnt     <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      prev_sample <= '0;
    end else begin
      wr_en   <= 1'b0;
      div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;

      // A write in flight always completes, even when aborted by cfg_stb.
      if (wr_en) begin
        wr_addr <= wr_addr + AW'(1);
      end

      if (cfg_stb) begin
        state    <= run ? S_PREFILL : S_IDLE;
        status   <= status_of(run ? S_PREFILL : S_IDLE);
        pre_cnt  <= '0;
        post_cnt <= '0;
        div_cnt  <= '0;
      end else begin
        if (issue) begin
          wr_en   <= 1'b1;
          wr_data <= {adc_b, adc_a};
        end

        if (busy_st && wr_en) begin
          prev_sample <= sample;
        end

        case (state)
          S_IDLE: begin
          end

          S_PREFILL: begin
            if (wr_en) begin
              pre_cnt <= pre_cnt + (AW+1)'(1);
              if (pre_last) begin
                state  <= S_ARMED;
                status <= status_of(S_ARMED);
              end
            end
          end

          S_ARMED: begin
            if (trig_hit) begin
              trig_addr <= wr_addr;
              post_cnt  <= '0;
              if (post_count == '0) begin
                state       <= S_DONE;
                status      <= status_of(S_DONE);
                oldest_addr <= wr_addr + AW'(1);
              end else begin
                state  <= S_POST;
                status <= status_of(S_POST);
              end
            end
          end

          S_POST: begin
            if (wr_en) begin
              post_cnt <= post_cnt + 11'd1;
              if (post_last) begin
                state       <= S_DONE;
                status      <= status_of(S_DONE);
                oldest_addr <= wr_addr + AW'(1);
              end
            end
          end

          S_DONE: begin
            if (rearm) begin
              state    <= S_PREFILL;
              status   <= status_of(S_PREFILL);
              pre_cnt  <= '0;
              post_cnt <= '0;
              div_cnt  <= '0;
            end
          end

          default: begin
            state  <= S_IDLE;
            status <= 4'b0000;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
`timescale 1ns/1ps
module tb_adc_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    adc_a;
  logic [7:0]    adc_b;
  logic [31:0]   adc_cfg;
  logic          cfg_stb;
  logic          rearm;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [15:0]   wr_data;
  logic [AW-1:0] trig_addr;
  logic [AW-1:0] oldest_addr;
  logic [3:0]    status;

  always #5 clk = ~clk;

  adc_capture_ctrl #(.AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .adc_a       (adc_a),
    .adc_b       (adc_b),
    .adc_cfg     (adc_cfg),
    .cfg_stb     (cfg_stb),
    .rearm       (rearm),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .trig_addr   (trig_addr),
    .oldest_addr (oldest_addr),
    .status      (status)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Input value presented at clock edge k after the start edge (k = 0).
  logic [7:0] ga [0:511];
  logic [7:0] gb [0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_cfg(input int div, input int post, input bit frc,
                                         input bit slope, input bit ch,
                                         input logic [7:0] level, input bit run);
    logic [31:0] c;
    logic [31:0] p;
    logic [31:0] dv;
    p  = post;
    dv = div;
    c  = '0;
    c[7:0]   = level;
    c[8]     = ch;
    c[9]     = slope;
    c[10]    = frc;
    c[11]    = run;
    c[22:12] = p[10:0];
    c[31:24] = dv[7:0];
    return c;
  endfunction

  function automatic int pre_len(input int post);
    return (post >= DEPTH - 1) ? 1 : DEPTH - post;
  endfunction

  // Writes observed in a capture window when no trigger is expected.
  function automatic int window_writes(input int d, input int pre);
    return ((d + 1) * (pre + 40) + 2) / (d + 1);
  endfunction

  // Per-tick ramp: tick m carries base + step*m on each channel.
  task automatic fill_ramp(input int d, input int ba, input int sa, input int bb, input int sb);
    for (int k = 0; k < 512; k++) begin
      int m;
      m = (k == 0) ? 0 : (k - 1) / (d + 1);
      ga[k] = 8'(ba + sa * m);
      gb[k] = 8'(bb + sb * m);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 512; k++) begin
      ga[k] = 8'($urandom_range(0, 255));
      gb[k] = 8'($urandom_range(0, 255));
    end
  endtask

  // Reference: scan the list of decimated samples; the first one after the
  // prefill that satisfies the trigger rule is the trigger. -1 = none.
  function automatic int model_trig(input logic [31:0] cfg, input int limit);
    int d;
    int pre;
    int lv;
    d   = int'(cfg[31:24]);
    pre = pre_len(int'(cfg[22:12]));
    lv  = int'(cfg[7:0]);
    for (int m = pre; m < limit; m++) begin
      int s;
      int p;
      s = cfg[8] ? int'(gb[(m + 1) * (d + 1)]) : int'(ga[(m + 1) * (d + 1)]);
      p = cfg[8] ? int'(gb[m * (d + 1)])       : int'(ga[m * (d + 1)]);
      if (cfg[10]) return m;
      if (!cfg[9] && p < lv && s >= lv) return m;
      if (cfg[9] && p > lv && s <= lv) return m;
    end
    return -1;
  endfunction

  // Expected status after edge k; write m finishes on edge (m+1)(d+1)+1.
  function automatic logic [3:0] exp_status(input int k, input int d, input int pre,
                                            input int t, input int n);
    if (n >= 0 && k >= n * (d + 1) + 1) return 4'b1100;
    if (t >= 0 && k >= (t + 1) * (d + 1) + 1) return 4'b0101;
    if (k >= pre * (d + 1) + 1) return 4'b0011;
    return 4'b0001;
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    cfg_stb = 1'b0;
    rearm   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Start a capture (cfg_stb or rearm) and follow it cycle by cycle.
  task automatic run_capture(input string tag, input logic [31:0] cfg, input bit use_rearm,
                             input int exp_t, input int exp_n, input int start,
                             input int exp_trig, input int exp_old);
    int d;
    int pre;
    int kmax;
    int wcount;
    int wr_err;
    int st_err;
    int exp_count;
    d      = int'(cfg[31:24]);
    pre    = pre_len(int'(cfg[22:12]));
    kmax   = (exp_n >= 0) ? exp_n * (d + 1) + 6 : (d + 1) * (pre + 40) + 2;
    wcount = 0;
    wr_err = 0;
    st_err = 0;
    adc_a   = ga[0];
    adc_b   = gb[0];
    adc_cfg = cfg;
    if (use_rearm) rearm = 1'b1;
    else cfg_stb = 1'b1;
    @(posedge clk);
    #1;
    cfg_stb = 1'b0;
    rearm   = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      adc_a = ga[k];
      adc_b = gb[k];
      @(posedge clk);
      @(negedge clk);
      if (status !== exp_status(k, d, pre, exp_t, exp_n)) st_err++;
      if (wr_en) begin
        if (exp_n >= 0 && wcount >= exp_n) wr_err++;
        else if (k != (wcount + 1) * (d + 1) || wr_addr !== AW'(start + wcount) ||
                 wr_data !== {gb[k], ga[k]}) wr_err++;
        wcount++;
      end
    end
    exp_count = (exp_n >= 0) ? exp_n : kmax / (d + 1);
    check({tag, "_write_count"}, 32'(wcount), 32'(exp_count));
    check({tag, "_write_trace_errors"}, 32'(wr_err), 32'd0);
    check({tag, "_status_trace_errors"}, 32'(st_err), 32'd0);
    if (exp_n >= 0) begin
      check({tag, "_trig_addr"}, 32'(trig_addr), 32'(exp_trig % DEPTH));
      check({tag, "_oldest_addr"}, 32'(oldest_addr), 32'(exp_old % DEPTH));
      check({tag, "_final_status"}, 32'(status), 32'h0000000c);
    end
  endtask

  typedef struct {
    string      name;
    int         div;
    int         post;
    bit         frc;
    bit         slope;
    bit         ch;
    logic [7:0] level;
    int         base_a;
    int         step_a;
    int         base_b;
    int         step_b;
    int         exp_t;
    int         exp_n;
    int         exp_trig;
    int         exp_old;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    bit in_done;
    int quiet_err;
    bit seen_post;

    // name, div, post, force, slope, ch, level, a base/step, b base/step,
    // trigger index, total writes, trig_addr, oldest_addr (capture from 0)
    vecs[0] = '{"rise_a",   0,  4, 1'b0, 1'b0, 1'b0, 8'h80, 8'h74, 1, 0,    0, 12, 17, 12, 1};
    vecs[1] = '{"force",    0,  4, 1'b1, 1'b0, 1'b0, 8'h80, 0,     1, 0,    1, 12, 17, 12, 1};
    vecs[2] = '{"post0",    0,  0, 1'b0, 1'b0, 1'b0, 8'h80, 8'h70, 1, 0,    0, 16, 17,  0, 1};
    vecs[3] = '{"fall_b",   0,  4, 1'b0, 1'b1, 1'b1, 8'h40, 8'hff, 0, 8'h50, -1, 16, 21, 0, 5};
    vecs[4] = '{"div3",     3,  4, 1'b0, 1'b0, 1'b0, 8'h80, 8'h74, 1, 0,    0, 12, 17, 12, 1};
    vecs[5] = '{"post15",   0, 15, 1'b0, 1'b0, 1'b0, 8'h80, 8'h7f, 1, 0,    0,  1, 17,  1, 1};
    vecs[6] = '{"post20",   1, 20, 1'b0, 1'b0, 1'b0, 8'h80, 8'h7f, 1, 0,    0,  1, 22,  1, 6};

    adc_a   = '0;
    adc_b   = '0;
    adc_cfg = '0;
    do_reset();
    @(negedge clk);
    check("reset_status", 32'(status), 32'd0);
    check("reset_wr_en", 32'(wr_en), 32'd0);
    check("reset_wr_addr", 32'(wr_addr), 32'd0);

    // Directed captures, each from reset.
    for (int i = 0; i < 7; i++) begin
      do_reset();
      fill_ramp(vecs[i].div, vecs[i].base_a, vecs[i].step_a, vecs[i].base_b, vecs[i].step_b);
      run_capture(vecs[i].name,
                  mk_cfg(vecs[i].div, vecs[i].post, vecs[i].frc, vecs[i].slope, vecs[i].ch,
                         vecs[i].level, 1'b1),
                  1'b0, vecs[i].exp_t, vecs[i].exp_n, 0, vecs[i].exp_trig, vecs[i].exp_old);
    end

    // Rearm alone from DONE (buffer ends at address 6): continues from there.
    fill_ramp(0, 8'h74, 1, 0, 0);
    run_capture("rearm", mk_cfg(0, 4, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1), 1'b1, 12, 17, 6, 2, 7);

    // cfg_stb and rearm together in DONE with run=0: cfg path wins -> IDLE.
    adc_cfg = mk_cfg(0, 4, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0);
    cfg_stb = 1'b1;
    rearm   = 1'b1;
    @(posedge clk);
    #1;
    cfg_stb = 1'b0;
    rearm   = 1'b0;
    @(negedge clk);
    check("stb_rearm_status", 32'(status), 32'd0);
    check("stb_rearm_trig_kept", 32'(trig_addr), 32'd2);
    check("stb_rearm_addr_kept", 32'(wr_addr), 32'd7);
    quiet_err = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || status !== 4'b0000) quiet_err++;
    end
    check("idle_quiet", 32'(quiet_err), 32'd0);

    // Reset in the middle of POST.
    fill_ramp(0, 8'h74, 1, 0, 0);
    adc_cfg = mk_cfg(0, 4, 1'b0, 1'b0, 1'b0, 8'h80, 1'b1);
    cfg_stb = 1'b1;
    @(posedge clk);
    #1 cfg_stb = 1'b0;
    seen_post = 1'b0;
    for (int k = 1; k < 200 && !seen_post; k++) begin
      adc_a = ga[k];
      @(posedge clk);
      @(negedge clk);
      if (status === 4'b0101) seen_post = 1'b1;
    end
    check("reach_post", 32'(seen_post), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midpost_rst_wr_en", 32'(wr_en), 32'd0);
    check("midpost_rst_wr_addr", 32'(wr_addr), 32'd0);
    check("midpost_rst_wr_data", 32'(wr_data), 32'd0);
    check("midpost_rst_trig_addr", 32'(trig_addr), 32'd0);
    check("midpost_rst_oldest", 32'(oldest_addr), 32'd0);
    check("midpost_rst_status", 32'(status), 32'd0);
    rst_n = 1'b1;
    quiet_err = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (wr_en !== 1'b0 || status !== 4'b0000) quiet_err++;
    end
    check("post_reset_quiet", 32'(quiet_err), 32'd0);
    cfg_stb = 1'b1;
    @(posedge clk);
    #1 cfg_stb = 1'b0;
    @(negedge clk);
    check("restart_busy", 32'(status), 32'd1);

    // Randomized captures against the sample-list model.
    do_reset();
    start   = 0;
    in_done = 1'b0;
    for (int it = 0; it < 12; it++) begin
      logic [31:0] cfg;
      int d;
      int post;
      int pre;
      int t;
      int n;
      bit use_rearm;
      d    = $urandom_range(0, 3);
      post = $urandom_range(0, 17);
      cfg  = mk_cfg(d, post, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'b1);
      pre  = pre_len(post);
      fill_random();
      t = model_trig(cfg, window_writes(d, pre));
      n = (t >= 0) ? t + 1 + post : -1;
      use_rearm = in_done && ($urandom_range(0, 1) == 1);
      run_capture($sformatf("rand%0d", it), cfg, use_rearm, t, n, start, start + t, start + n);
      if (t >= 0) begin
        start   = (start + n) % DEPTH;
        in_done = 1'b1;
      end else begin
        do_reset();
        start   = 0;
        in_done = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
